// File: rtl/nco_phase_gen.sv
// Phase-accumulator sample scheduler feeding the CORDIC stage: periodic tick, angle/strobe issue, overrun tracking.
// Optional angle dither is built when NCO_PHASE_DITHER_EN is defined.
module nco_phase_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned OVR_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] pow,
  input  logic [DIV_W-1:0]   div,
  input  logic               cordic_done,
  input  logic               ovr_clear,
  output logic [PHASE_W-1:0] angle,
  output logic               strobe,
  output logic               busy,
  output logic               overrun,
  output logic [OVR_W-1:0]   ovr_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   reload;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] candidate;
  logic               tick;
  logic               issue;
  logic               drop;

  assign reload = (div == '0) ? '0 : div - 1'b1;
  assign tick   = enable && (div_cnt == '0);

`ifdef NCO_PHASE_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (issue) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign candidate = acc + pow + PHASE_W'(lfsr[7:0]);
`else
  assign candidate = acc + pow;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || (div_cnt == '0)) begin
      div_cnt <= reload;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A tick coinciding with cordic_done is issued and keeps the block in WAIT.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          issue   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tick && cordic_done) begin
          issue = 1'b1;
        end else if (tick) begin
          drop = 1'b1;
        end else if (cordic_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      angle  <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= issue;
      if (tick) begin
        acc <= acc + ftw;
      end
      if (issue) begin
        angle <= candidate;
      end
    end
  end

  // A dropped tick outranks ovr_clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      ovr_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (ovr_clear) begin
        ovr_cnt <= OVR_W'(1);
      end else if (ovr_cnt != '1) begin
        ovr_cnt <= ovr_cnt + 1'b1;
      end
    end else if (ovr_clear) begin
      overrun <= 1'b0;
      ovr_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed self-checking bench for nco_phase_gen with a latency-programmable CORDIC responder.
module tb_nco_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] ftw = '0;
  logic [31:0] pow = '0;
  logic [15:0] div = '0;
  logic        cordic_done;
  logic        ovr_clear = 1'b0;
  logic [31:0] angle;
  logic        strobe;
  logic        busy;
  logic        overrun;
  logic [7:0]  ovr_cnt;

  logic        done_auto = 1'b0;
  logic        done_man = 1'b0;
  logic        auto_en = 1'b0;
  int          done_lat = 1;
  int          pend = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  assign cordic_done = done_auto | done_man;

  nco_phase_gen #(.PHASE_W(32), .DIV_W(16), .OVR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ftw         (ftw),
    .pow         (pow),
    .div         (div),
    .cordic_done (cordic_done),
    .ovr_clear   (ovr_clear),
    .angle       (angle),
    .strobe      (strobe),
    .busy        (busy),
    .overrun     (overrun),
    .ovr_cnt     (ovr_cnt)
  );

  always #5 clk = ~clk;

  // CORDIC model: pulses done done_lat cycles after each observed strobe.
  always @(negedge clk) begin
    done_auto = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) done_auto = 1'b1;
    end
    if (strobe && auto_en) pend = done_lat;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_strobe(input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!strobe && cyc < maxc);
    if (!strobe) check("strobe_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    ovr_clear = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int c;

  initial begin
    // Reset state and basic issue with fast CORDIC.
    div = 16'd4; ftw = 32'h00B60B60; pow = '0; done_lat = 2; auto_en = 1'b1;
    do_reset();
    check("rst_angle", 64'(angle), 64'd0);
    check("rst_strobe", 64'(strobe), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_ovr_cnt", 64'(ovr_cnt), 64'd0);
    enable = 1'b1;
    next_strobe(10, c);
    check("t1_first_lat", 64'(c), 64'd4);
    check("t1_angle0", 64'(angle), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      next_strobe(10, c);
      check("t1_period", 64'(c), 64'd4);
      check("t1_angle", 64'(angle), 64'(32'h00B60B60 * i));
    end
    check("t1_overrun", 64'(overrun), 64'd0);

    // Phase offset and silent wrap.
    div = 16'd20; ftw = 32'h40000000; pow = 32'h20000000; done_lat = 3;
    do_reset();
    enable = 1'b1;
    next_strobe(25, c);
    check("t2_first_lat", 64'(c), 64'd20);
    check("t2_a0", 64'(angle), 64'h20000000);
    next_strobe(25, c); check("t2_a1", 64'(angle), 64'h60000000);
    next_strobe(25, c); check("t2_a2", 64'(angle), 64'hA0000000);
    next_strobe(25, c); check("t2_a3", 64'(angle), 64'hE0000000);
    next_strobe(25, c); check("t2_a4_wrap", 64'(angle), 64'h20000000);

    // Slow CORDIC: two dropped ticks per issue, accumulator keeps advancing.
    div = 16'd2; ftw = 32'h00000100; pow = '0; done_lat = 5;
    do_reset();
    enable = 1'b1;
    next_strobe(5, c);
    check("t3_a0", 64'(angle), 64'd0);
    check("t3_ovr0", 64'(ovr_cnt), 64'd0);
    next_strobe(10, c);
    check("t3_period", 64'(c), 64'd6);
    check("t3_a1", 64'(angle), 64'h300);
    check("t3_ovr_cnt", 64'(ovr_cnt), 64'd2);
    check("t3_overrun", 64'(overrun), 64'd1);
    enable = 1'b0;
    @(negedge clk);
    check("t3_hold_busy", 64'(busy), 64'd1);
    repeat (7) @(negedge clk);
    check("t3_done_busy", 64'(busy), 64'd0);
    check("t3_ovr_kept", 64'(ovr_cnt), 64'd2);
    ovr_clear = 1'b1;
    @(negedge clk);
    ovr_clear = 1'b0;
    check("t3_clr_overrun", 64'(overrun), 64'd0);
    check("t3_clr_cnt", 64'(ovr_cnt), 64'd0);

    // Done coinciding with tick: back-to-back issue, busy never drops.
    div = 16'd2; ftw = 32'h00000010; pow = '0; done_lat = 1;
    do_reset();
    enable = 1'b1;
    next_strobe(5, c);
    check("t4_a0", 64'(angle), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("t4_busy_gap", 64'(busy), 64'd1);
      check("t4_no_strobe", 64'(strobe), 64'd0);
      next_strobe(4, c);
      check("t4_gap", 64'(c), 64'd1);
      check("t4_angle", 64'(angle), 64'(32'h10 * i));
      check("t4_busy", 64'(busy), 64'd1);
    end
    check("t4_ovr_cnt", 64'(ovr_cnt), 64'd0);

    // Saturation with CORDIC never answering, then clear colliding with overrun.
    auto_en = 1'b0;
    div = 16'd1; ftw = 32'h00000001; pow = '0;
    do_reset();
    enable = 1'b1;
    next_strobe(3, c);
    check("t5_lat", 64'(c), 64'd1);
    repeat (10) @(negedge clk);
    check("t5_cnt10", 64'(ovr_cnt), 64'd10);
    repeat (290) @(negedge clk);
    check("t5_sat", 64'(ovr_cnt), 64'd255);
    check("t5_overrun", 64'(overrun), 64'd1);
    ovr_clear = 1'b1;
    @(negedge clk);
    ovr_clear = 1'b0;
    check("t5_clr_race_cnt", 64'(ovr_cnt), 64'd1);
    check("t5_clr_race_flag", 64'(overrun), 64'd1);
    @(negedge clk);
    check("t5_after_clr", 64'(ovr_cnt), 64'd2);

    // Asynchronous reset mid-WAIT, stray done afterwards.
    check("t6_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("t6_angle", 64'(angle), 64'd0);
    check("t6_strobe", 64'(strobe), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_overrun", 64'(overrun), 64'd0);
    check("t6_ovr_cnt", 64'(ovr_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    div = 16'd3; ftw = 32'h11111111; pow = 32'h12345678;
    @(negedge clk);
    done_man = 1'b1;
    @(negedge clk);
    done_man = 1'b0;
    @(negedge clk);
    check("t6_stray_busy", 64'(busy), 64'd0);
    check("t6_stray_strobe", 64'(strobe), 64'd0);
    enable = 1'b1;
    next_strobe(6, c);
    check("t6_lat", 64'(c), 64'd3);
    check("t6_angle_pow", 64'(angle), 64'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
